pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Program-counter register stage of the pipeline fetch path. It is the direct consumer of the next-PC 2:1 multiplexer (sequential PC vs. branch/jump target) and drives the instruction-memory address. It supports hazard stalls, a debug single-step mode and a HALT state, and keeps cycle and fetch counters for the debug unit.

Parameters:
PC_WIDTH, 32, width of the PC and of the next-PC input.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment for o_pc_plus4.
CNT_WIDTH, 32, width of the cycle and fetch counters.

Ports:
i_clock  in  1  system clock; all state updates on its rising edge.
i_reset  in  1  synchronous reset, active-high.
i_next_pc  in  PC_WIDTH  next PC, taken from the MUX2to1 output.
i_stall  in  1  hazard stall; holds the PC.
i_halt  in  1  HALT instruction decoded for the current PC.
i_step_mode  in  1  1 = debug step mode, 0 = free run.
i_step  in  1  step request, level signal; the unit detects the rising edge internally.
o_pc  out  PC_WIDTH  current PC, registered.
o_pc_plus4  out  PC_WIDTH  o_pc + PC_STEP, combinational, wraps modulo 2^PC_WIDTH.
o_valid  out  1  current o_pc is a live fetch, registered.
o_halted  out  1  unit is in HALTED, registered.
o_misaligned  out  1  one-cycle pulse when a loaded i_next_pc had nonzero bits [1:0].
o_cycle_count  out  CNT_WIDTH  clocks spent outside HALTED.
o_fetch_count  out  CNT_WIDTH  number of PC advances.

Behaviour:
- Reset values while i_reset=1 at a clock edge: o_pc=RESET_PC, o_valid=0, o_halted=0, o_misaligned=0, both counters=0, state=RUN, step edge detector cleared. A reset asserted mid-step or while halted overrides everything.
- States:
  - RUN: PC advances every cycle.
  - STEP: PC advances only on cycles where a step edge is detected.
  - HALTED: absorbing; left only by reset.
- The state register follows i_step_mode between RUN and STEP at each edge, unless the unit is HALTED.
- Advance condition (adv): state!=HALTED, i_stall=0, i_halt=0, and either state=RUN or a step edge. A step edge is i_step=1 with the previous sample of i_step=0.
- On adv:
  - o_pc <= {i_next_pc[PC_WIDTH-1:2], 2'b00}.
  - o_misaligned <= |i_next_pc[1:0]; otherwise it is 0 next cycle.
  - o_fetch_count increments.
- Latency: 1 clock from i_next_pc to o_pc.
- o_valid <= adv. It is 0 during stall, during step-wait and while halted. The first valid fetch comes 1 cycle after reset is released, in RUN.
- i_halt=1 while state!=HALTED and o_valid=1: next state is HALTED, o_halted<=1, o_pc held at the HALT address.
- Priority: reset > halt > stall > step gating.
  - i_halt and i_stall together: halt wins.
  - A step edge during a stall is consumed and lost; no advance.
- o_cycle_count increments every clock with state!=HALTED. Both counters saturate at all-ones; they do not wrap.
- The PC itself wraps: i_next_pc=32'hFFFF_FFFC is legal, and o_pc_plus4 is then 0.

Decomposition:
- Shared pipeline package:
  - State encoding localparams: ST_RUN=2'd0, ST_STEP=2'd1, ST_HALTED=2'd2.
  - PC_WIDTH and RESET_PC defaults, shared with the instruction memory and MUX2to1 instances.
- Sub-module sat_counter (parameter WIDTH; inputs i_clock, i_reset, i_inc; output o_count; saturating). Instantiated twice.
- The step edge detector stays inline.

Test Plan:
- Reset, then run with i_next_pc driven from o_pc_plus4 -> o_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles; o_fetch_count = 4 after 4 advances.
- In RUN, assert i_stall for 3 cycles at PC 0x8 -> o_pc held at 0x8, o_valid=0 for those 3 cycles, o_cycle_count still +3.
- Step mode, i_step held high 5 cycles then low, then pulsed again -> exactly one advance per rising edge (0x0 to 0x4 to 0x8), o_valid high for exactly one cycle each.
- i_halt at PC 0x10 together with i_stall=1 -> o_halted=1 next cycle, o_pc stays 0x10 forever, o_cycle_count freezes. Then i_reset -> o_pc=0x0, o_halted=0.
- i_next_pc=0x0000_0006 -> o_pc=0x4 and an o_misaligned pulse of one cycle. Then i_next_pc=0xFFFF_FFFC -> o_pc_plus4=0x0.
- Bench counter forced near 2^CNT_WIDTH-1 (CNT_WIDTH=4 build) -> count stops at 4'hF with no wrap; a reset mid-run clears it to 0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared fetch-path definitions: PC defaults and the PC-stage state encoding.
// No logic; consumed by pc_unit, the instruction memory and the next-PC mux.
// Keep defaults here so every fetch-path instance agrees on PC width/reset.
package pc_unit_pkg;

    localparam int          DEF_PC_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    // Instruction fetches are word aligned; any low bit set is a bad target.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/pc_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency 1 clock from i_inc to o_count; no backpressure.
// Synchronous active-high reset clears the count.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register stage with stall, debug single-step and HALT.
// Latency 1 clock from i_next_pc to o_pc; o_pc_plus4 is combinational.
// Stall/halt/step-wait hold the PC and drop o_valid; there is no ready path.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                    PC_WIDTH  = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = PC_WIDTH'(DEF_RESET_PC),
    parameter int                    PC_STEP   = 4,
    parameter int                    CNT_WIDTH = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [PC_WIDTH-1:0]  i_next_pc,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic [PC_WIDTH-1:0]  o_pc_plus4,
    output logic                 o_valid,
    output logic                 o_halted,
    output logic                 o_misaligned,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic [CNT_WIDTH-1:0] o_fetch_count
);

    pc_state_e state;
    logic      step_q;
    logic      step_edge;
    logic      halt_take;
    logic      adv;
    logic      cyc_inc;

    // Halt only commits against a live fetch; it outranks stall and stepping.
    always_comb begin
        step_edge = i_step & ~step_q;
        halt_take = i_halt && (state != ST_HALTED) && o_valid;
        adv       = (state != ST_HALTED) && !i_stall && !i_halt &&
                    ((state == ST_RUN) || step_edge);
        cyc_inc   = (state != ST_HALTED);
    end

    assign o_pc_plus4 = o_pc + PC_WIDTH'(PC_STEP);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= ST_RUN;
            step_q       <= 1'b0;
            o_pc         <= RESET_PC;
            o_valid      <= 1'b0;
            o_halted     <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            // Sampled every cycle so an edge seen during a stall is consumed.
            step_q       <= i_step;
            o_valid      <= adv;
            o_misaligned <= adv && is_misaligned(i_next_pc[1:0]);
            if (adv) begin
                o_pc <= {i_next_pc[PC_WIDTH-1:2], 2'b00};
            end
            if (halt_take) begin
                state    <= ST_HALTED;
                o_halted <= 1'b1;
            end else if (state != ST_HALTED) begin
                state <= i_step_mode ? ST_STEP : ST_RUN;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (cyc_inc),
        .o_count (o_cycle_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_fetch_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (adv),
        .o_count (o_fetch_count)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit-counter instance plus a 4-bit-counter
// instance for saturation.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc_drv;
    logic        use_fb;
    logic        stall, halt, step_mode, step;
    logic [31:0] pc, pc_plus4, next_pc;
    logic        valid, halted, mis;
    logic [31:0] cyc, fetch;

    logic        rst2;
    logic [31:0] pc2, pc2_plus4;
    logic        valid2, halted2, mis2;
    logic [3:0]  cyc2, fetch2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign next_pc = use_fb ? pc_plus4 : next_pc_drv;

    pc_unit dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_next_pc     (next_pc),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_step_mode   (step_mode),
        .i_step        (step),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4),
        .o_valid       (valid),
        .o_halted      (halted),
        .o_misaligned  (mis),
        .o_cycle_count (cyc),
        .o_fetch_count (fetch)
    );

    pc_unit #(.CNT_WIDTH(4)) dut4 (
        .i_clock       (clk),
        .i_reset       (rst2),
        .i_next_pc     (pc2_plus4),
        .i_stall       (1'b0),
        .i_halt        (1'b0),
        .i_step_mode   (1'b0),
        .i_step        (1'b0),
        .o_pc          (pc2),
        .o_pc_plus4    (pc2_plus4),
        .o_valid       (valid2),
        .o_halted      (halted2),
        .o_misaligned  (mis2),
        .o_cycle_count (cyc2),
        .o_fetch_count (fetch2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; use_fb = 1'b1; next_pc_drv = 32'h0;
        stall = 1'b0; halt = 1'b0; step_mode = 1'b0; step = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_plus4", pc_plus4, 32'h4);
        chk("rst_valid", valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mis", mis, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_fetch", fetch, 0);

        // Free run with feedback from o_pc_plus4
        rst = 1'b0;
        tick();
        chk("run1_pc", pc, 32'h4);
        chk("run1_valid", valid, 1);
        chk("run1_fetch", fetch, 1);
        chk("run1_cyc", cyc, 1);
        tick();
        chk("run2_pc", pc, 32'h8);

        // Three-cycle stall at 0x8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h8);
            chk("stall_valid", valid, 0);
        end
        chk("stall_cyc", cyc, 5);
        chk("stall_fetch", fetch, 2);
        stall = 1'b0;
        tick();
        chk("resume_pc", pc, 32'hC);
        chk("resume_valid", valid, 1);
        tick();
        chk("run4_pc", pc, 32'h10);
        chk("run4_fetch", fetch, 4);
        chk("run4_cyc", cyc, 7);

        // Halt with simultaneous stall at 0x10
        halt = 1'b1; stall = 1'b1;
        tick();
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 32'h10);
        chk("halt_valid", valid, 0);
        chk("halt_cyc", cyc, 8);
        halt = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("halted_pc", pc, 32'h10);
        chk("halted_hold", halted, 1);
        chk("halted_cyc", cyc, 8);
        chk("halted_fetch", fetch, 4);

        rst = 1'b1;
        tick();
        chk("unhalt_pc", pc, 32'h0);
        chk("unhalt_halted", halted, 0);
        chk("unhalt_cyc", cyc, 0);

        // Step mode; first cycle stalled so the state settles to STEP
        step_mode = 1'b1; rst = 1'b0; stall = 1'b1;
        tick();
        chk("stepinit_pc", pc, 32'h0);
        stall = 1'b0; step = 1'b1;
        tick();
        chk("step1_pc", pc, 32'h4);
        chk("step1_valid", valid, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stephold_pc", pc, 32'h4);
            chk("stephold_valid", valid, 0);
        end
        step = 1'b0;
        tick();
        chk("steplow_valid", valid, 0);
        step = 1'b1;
        tick();
        chk("step2_pc", pc, 32'h8);
        chk("step2_valid", valid, 1);
        step = 1'b0;
        tick();
        chk("step2_after", valid, 0);

        // Step edge during a stall is lost
        step = 1'b1; stall = 1'b1;
        tick();
        chk("stepstall_pc", pc, 32'h8);
        stall = 1'b0;
        tick();
        chk("steplost_pc", pc, 32'h8);
        chk("steplost_valid", valid, 0);
        chk("step_fetch", fetch, 2);
        step = 1'b0;

        // Back to RUN, direct next-PC values
        step_mode = 1'b0; use_fb = 1'b0; next_pc_drv = 32'h100;
        tick();
        chk("torun_pc", pc, 32'h8);
        next_pc_drv = 32'h6;
        tick();
        chk("mis_pc", pc, 32'h4);
        chk("mis_pulse", mis, 1);
        next_pc_drv = 32'h20;
        tick();
        chk("mis_clear", mis, 0);
        chk("aligned_pc", pc, 32'h20);
        next_pc_drv = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        next_pc_drv = 32'hFFFF_FFFF;
        tick();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_mis", mis, 1);

        // 4-bit counters saturate, then reset clears
        rst2 = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("c4_cyc14", cyc2, 4'hE);
        chk("c4_fetch14", fetch2, 4'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("c4_cyc_sat", cyc2, 4'hF);
        chk("c4_fetch_sat", fetch2, 4'hF);
        rst2 = 1'b1;
        tick();
        chk("c4_cyc_rst", cyc2, 4'h0);
        chk("c4_fetch_rst", fetch2, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
